// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB entry layout, region attribute layout and the
// state encoding of the TLB initialisation walker.
package mmu_pkg;

    localparam int unsigned PPN_W  = 28;
    localparam int unsigned VPN_W  = 20;
    localparam int unsigned ATTR_W = 9;

    typedef struct packed {
        logic             v;
        logic             lock;
        logic [2:0]       lvl;
        logic [2:0]       rwx;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } tlb_entry_t;

    localparam int unsigned ENTRY_W = $bits(tlb_entry_t);

    typedef struct packed {
        logic       lock;
        logic [2:0] lvl;
        logic [2:0] rwx;
        logic [1:0] way;
    } tlb_region_attr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } tlb_init_state_e;

endpackage

// File: rtl/tlb_init_machine_region_match.sv
// Finds the lowest-numbered region covering (way, set) and the page offset
// of that set inside the region.
module tlb_region_match
    import mmu_pkg::*;
#(
    parameter int unsigned WID  = 9,
    parameter int unsigned WWID = 2,
    parameter int unsigned NREG = 4
) (
    input  logic [WID-1:0]         set,
    input  logic [WWID-1:0]        way,
    input  logic [NREG*16-1:0]     region_start,
    input  logic [NREG*16-1:0]     region_count,
    input  logic [NREG*ATTR_W-1:0] region_attr,
    output logic                   hit,
    output logic [2:0]             idx,
    output logic [15:0]            k,
    output logic [6:0]             perm
);

    tlb_region_attr_t attr;
    logic [16:0]      lo;
    logic [16:0]      hi;

    // Walk from the highest region down so the lowest hit overwrites last.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        k    = '0;
        perm = '0;
        attr = '0;
        lo   = '0;
        hi   = '0;
        for (int r = int'(NREG) - 1; r >= 0; r--) begin
            attr = tlb_region_attr_t'(region_attr[r*ATTR_W +: ATTR_W]);
            lo   = {1'b0, region_start[r*16 +: 16]};
            hi   = lo + {1'b0, region_count[r*16 +: 16]};
            if ((region_count[r*16 +: 16] != 16'd0) && (attr.way == 2'(way)) &&
                (17'(set) >= lo) && (17'(set) < hi)) begin
                hit  = 1'b1;
                idx  = 3'(r);
                k    = 16'(17'(set) - lo);
                perm = {attr.lock, attr.lvl, attr.rwx};
            end
        end
    end

endmodule

// File: rtl/tlb_init_machine.sv
// Walks every (way, set) of a set-associative TLB after reset or on request,
// writing region-mapped entries or invalid entries over a req/ack port.
module tlb_init_machine
    import mmu_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES  = 512,
    parameter int unsigned TLB_WAYS     = 4,
    parameter int unsigned LOG_PAGESIZE = 13,
    parameter int unsigned NREG         = 4,
    parameter logic [NREG*16-1:0]     REG_START = (NREG*16)'(16'd4),
    parameter logic [NREG*16-1:0]     REG_COUNT = (NREG*16)'(16'd3),
    parameter logic [NREG*64-1:0]     REG_VA    = (NREG*64)'(64'hFF80_0000),
    parameter logic [NREG*64-1:0]     REG_PA    = (NREG*64)'(64'hFF80_0000),
    parameter logic [NREG*ATTR_W-1:0] REG_ATTR  = (NREG*ATTR_W)'(9'h01C),
    parameter bit                     AUTO_START = 1'b1,
    localparam int unsigned WID  = $clog2(TLB_ENTRIES),
    localparam int unsigned WWID = (TLB_WAYS > 1) ? $clog2(TLB_WAYS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               wr_req,
    input  logic               wr_ack,
    output logic [WWID-1:0]    wr_way,
    output logic [WID-1:0]     entry_no,
    output logic [ENTRY_W-1:0] entry,
    output logic               busy,
    output logic               done
);

    localparam logic [WID-1:0]  SET_LAST = WID'(TLB_ENTRIES - 1);
    localparam logic [WWID-1:0] WAY_LAST = WWID'(TLB_WAYS - 1);

    tlb_init_state_e state_q, state_d;
    logic [WID-1:0]  set_q, set_d;
    logic [WWID-1:0] way_q, way_d;
    logic            load;
    logic            wr_req_d, busy_d, done_d;
    tlb_entry_t      entry_q, entry_calc;

    logic            hit;
    logic [2:0]      idx;
    logic [15:0]     k;
    logic [6:0]      perm;
    logic [63:0]     va_sel, pa_sel;

    assign entry    = entry_q;
    assign entry_no = set_q;
    assign wr_way   = way_q;

    // The match looks at the next counter values so the entry is ready with wr_req.
    tlb_region_match #(
        .WID  (WID),
        .WWID (WWID),
        .NREG (NREG)
    ) u_match (
        .set          (set_d),
        .way          (way_d),
        .region_start (REG_START),
        .region_count (REG_COUNT),
        .region_attr  (REG_ATTR),
        .hit          (hit),
        .idx          (idx),
        .k            (k),
        .perm         (perm)
    );

    always_comb begin
        va_sel = '0;
        pa_sel = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            if (idx == 3'(r)) begin
                va_sel = REG_VA[r*64 +: 64];
                pa_sel = REG_PA[r*64 +: 64];
            end
        end
        entry_calc = '0;
        if (hit) begin
            entry_calc.v    = 1'b1;
            entry_calc.lock = perm[6];
            entry_calc.lvl  = perm[5:3];
            entry_calc.rwx  = perm[2:0];
            entry_calc.ppn  = PPN_W'((pa_sel >> LOG_PAGESIZE) + 64'(k));
            entry_calc.vpn  = VPN_W'(((va_sel >> LOG_PAGESIZE) + 64'(k)) >> WID);
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AUTO_START || start) state_d = ST_ARM;
            end
            ST_ARM: begin
                set_d   = '0;
                way_d   = '0;
                load    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_ack) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (set_q == SET_LAST) begin
                    set_d = '0;
                    way_d = (way_q == WAY_LAST) ? '0 : way_q + 1'b1;
                end else begin
                    set_d = set_q + 1'b1;
                end
                if ((set_q == SET_LAST) && (way_q == WAY_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                    load    = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_ARM;
            end
            default: state_d = ST_IDLE;
        endcase
        wr_req_d = (state_d == ST_WRITE);
        busy_d   = (state_d == ST_ARM) || (state_d == ST_WRITE) || (state_d == ST_NEXT);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            way_q   <= '0;
            entry_q <= '0;
            wr_req  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            wr_req  <= wr_req_d;
            busy    <= busy_d;
            done    <= done_d;
            if (load) entry_q <= entry_calc;
        end
    end

endmodule

// File: tb/tb_tlb_init_machine.sv
// Bench for tlb_init_machine: 8 sets x 2 ways, four regions (overlap, clipping,
// disabled), random write back-pressure and a scoreboard fed by a region model.
module tb_tlb_init_machine;
    import mmu_pkg::*;

    localparam int unsigned E  = 8;
    localparam int unsigned W  = 2;
    localparam int unsigned NR = 4;
    localparam longint unsigned PAGE = 64'd8192;

    localparam logic [NR*16-1:0] P_START = {16'd0, 16'd6, 16'd5, 16'd4};
    localparam logic [NR*16-1:0] P_COUNT = {16'd0, 16'd4, 16'd2, 16'd3};
    localparam logic [NR*64-1:0] P_VA = {64'h0000_0000_0000_2000, 64'h0000_0040_0000_0000,
                                         64'h0000_0000_4000_0000, 64'h0000_0000_FF80_0000};
    localparam logic [NR*64-1:0] P_PA = {64'h0000_0000_0000_4000, 64'h0000_0001_0000_2000,
                                         64'h0000_0000_1234_0000, 64'h0000_0000_FF80_0000};
    localparam logic [NR*9-1:0]  P_ATTR = {9'h0E5, 9'h135, 9'h14C, 9'h01C};

    // Same regions written as plain per-field tables for the model.
    longint unsigned m_va [NR] = '{64'hFF80_0000, 64'h4000_0000, 64'h40_0000_0000, 64'h2000};
    longint unsigned m_pa [NR] = '{64'hFF80_0000, 64'h1234_0000, 64'h1_0000_2000, 64'h4000};
    int m_start [NR] = '{4, 5, 6, 0};
    int m_cnt   [NR] = '{3, 2, 4, 0};
    int m_way   [NR] = '{0, 0, 1, 1};
    int m_lock  [NR] = '{0, 1, 1, 0};
    int m_lvl   [NR] = '{0, 2, 1, 7};
    int m_rwx   [NR] = '{7, 3, 5, 1};

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic               start  = 1'b0;
    logic               wr_ack = 1'b0;
    logic               wr_req, busy, done;
    logic [0:0]         wr_way;
    logic [2:0]         entry_no;
    logic [ENTRY_W-1:0] entry;

    typedef struct {
        int         way;
        int         set;
        tlb_entry_t e;
    } exp_t;

    exp_t sb[$];
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   writes_done = 0;
    int   ack_mode    = 0;
    int   stall_cnt   = 0;
    bit   stalled     = 1'b0;

    tlb_init_machine #(
        .TLB_ENTRIES  (E),
        .TLB_WAYS     (W),
        .LOG_PAGESIZE (13),
        .NREG         (NR),
        .REG_START    (P_START),
        .REG_COUNT    (P_COUNT),
        .REG_VA       (P_VA),
        .REG_PA       (P_PA),
        .REG_ATTR     (P_ATTR),
        .AUTO_START   (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .wr_way   (wr_way),
        .entry_no (entry_no),
        .entry    (entry),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic tlb_entry_t model(int w, int s);
        tlb_entry_t      e;
        longint unsigned k;
        e = '0;
        for (int r = 0; r < int'(NR); r++) begin
            if (m_cnt[r] > 0 && m_way[r] == w && s >= m_start[r] && s < m_start[r] + m_cnt[r]) begin
                k      = 64'(s - m_start[r]);
                e.v    = 1'b1;
                e.lock = 1'(m_lock[r]);
                e.lvl  = 3'(m_lvl[r]);
                e.rwx  = 3'(m_rwx[r]);
                e.ppn  = PPN_W'(m_pa[r] / PAGE + k);
                e.vpn  = VPN_W'((m_va[r] / PAGE + k) / 64'(E));
                return e;
            end
        end
        return e;
    endfunction

    task automatic push_walk();
        exp_t x;
        for (int w = 0; w < int'(W); w++) begin
            for (int s = 0; s < int'(E); s++) begin
                x.way = w;
                x.set = s;
                x.e   = model(w, s);
                sb.push_back(x);
            end
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    // Write-port responder: always ready, or random back-pressure with one
    // forced 5-cycle stall on the third write of a walk.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 0) begin
                wr_ack = 1'b1;
            end else if (stall_cnt > 0) begin
                wr_ack = 1'b0;
                stall_cnt--;
            end else if (wr_req && writes_done == 2 && !stalled) begin
                stalled   = 1'b1;
                stall_cnt = 4;
                wr_ack    = 1'b0;
            end else begin
                wr_ack = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: every accepted write is popped against the scoreboard.
    logic               prev_stall = 1'b0;
    logic [ENTRY_W-1:0] prev_entry;
    logic [2:0]         prev_no;
    logic [0:0]         prev_way;
    exp_t               got_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_req", 64'(wr_req), 64'd1);
                check("hold_data", 64'({entry, entry_no, wr_way}),
                      64'({prev_entry, prev_no, prev_way}));
            end
            if (wr_req && wr_ack) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_write: way %0d set %0d with nothing expected", wr_way, entry_no);
                end else begin
                    got_exp = sb.pop_front();
                    check("wr_way", 64'(wr_way), 64'(got_exp.way));
                    check("entry_no", 64'(entry_no), 64'(got_exp.set));
                    check("entry", 64'(entry), 64'(got_exp.e));
                end
                writes_done++;
            end
            prev_stall = wr_req && !wr_ack;
            prev_entry = entry;
            prev_no    = entry_no;
            prev_way   = wr_way;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  found;

        #12;
        check("reset_state", 64'({wr_req, busy, done, entry, entry_no, wr_way}), 64'd0);

        // Always-ready walk from reset release; done on the 34th edge
        // (cycle 33 counting the first edge as cycle 0).
        ack_mode = 0;
        push_walk();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) break;
        end
        check("done_cycle", 64'(cyc), 64'(2 * E * W + 2));
        check("walk1_all_popped", 64'(sb.size()), 64'd0);
        check("walk1_busy_low", 64'(busy), 64'd0);
        check("walk1_writes", 64'(writes_done), 64'(E * W));

        // Restart from DONE under back-pressure, with a mid-walk start that must be ignored.
        ack_mode    = 1;
        stalled     = 1'b0;
        writes_done = 0;
        push_walk();
        pulse_start();
        @(negedge clk);
        check("done_cleared", 64'(done), 64'd0);
        check("busy_after_start", 64'(busy), 64'd1);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (writes_done >= 6) found = 1'b1;
        end
        check("reach_mid_walk", 64'(found), 64'd1);
        pulse_start();
        @(negedge clk);
        check("midwalk_start_busy", 64'(busy), 64'd1);
        check("midwalk_start_done", 64'(done), 64'd0);
        wait_done("walk2_done");
        check("walk2_all_popped", 64'(sb.size()), 64'd0);
        check("walk2_writes", 64'(writes_done), 64'(E * W));

        // Reset during write 5 aborts at once; the auto walk restarts from (0,0).
        stalled     = 1'b1;
        writes_done = 0;
        push_walk();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (wr_req && (writes_done - (wr_ack ? 1 : 0)) == 4) found = 1'b1;
        end
        check("reach_write5", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_abort", 64'({wr_req, busy, done}), 64'd0);
        check("async_abort_idx", 64'({entry, entry_no, wr_way}), 64'd0);
        sb.delete();
        writes_done = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        push_walk();
        rst_n = 1'b1;
        wait_done("walk3_done");
        check("walk3_all_popped", 64'(sb.size()), 64'd0);
        check("walk3_writes", 64'(writes_done), 64'(E * W));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_init_machine.md
Name: tlb_init_machine

Overview:
Parametrised successor to the fixed TLB reset walker. After reset, or on software request, it writes every entry of a set-associative TLB (all ways × all sets). It uses a table of up to NREG parameter-defined regions, each giving a VA base, PA base, page count, start index, way and attributes. Entries not covered by any region are written invalid. Writes go to the TLB write port over a req/ack handshake; there is no fire-and-forget counter.

Parameters:
TLB_ENTRIES, 512, sets per way (power of two); WID=$clog2(TLB_ENTRIES)
TLB_WAYS, 4, ways (power of two, 1..4); WWID=max(1,$clog2(TLB_WAYS))
LOG_PAGESIZE, 13, log2 page size
NREG, 4, number of region descriptors (1..8)
REG_START, packed NREG×16, first set index of each region
REG_COUNT, packed NREG×16, pages in each region; 0 disables the region
REG_VA, packed NREG×64, virtual base address (page aligned)
REG_PA, packed NREG×64, physical base address (page aligned)
REG_ATTR, packed NREG×9, {lock, lvl[2:0], rwx[2:0], way[1:0]}
AUTO_START, 1, begin the walk automatically on the first clock after reset release

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse requesting a re-walk
wr_req  out  1  entry/entry_no/wr_way are valid
wr_ack  in  1  TLB accepted the write this cycle
wr_way  out  WWID  target way
entry_no  out  WID  target set index
entry  out  $bits(tlb_entry_t)  entry to write
busy  out  1  walk in progress
done  out  1  level; high once a walk completes, cleared by start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; way/set counters=0; wr_req=0; busy=0; done=0; entry=0.
- States: IDLE, ARM, WRITE, NEXT, DONE.
- IDLE: if AUTO_START, go to ARM on the first clock after release. Otherwise wait for start.
- ARM: counters=0; busy=1; done=0. Go to WRITE. Registers the entry for (way 0, set 0).
- WRITE: wr_req=1 with registered entry/entry_no/wr_way. Outputs hold stable until wr_ack. On wr_ack go to NEXT. No timeout.
- NEXT: wr_req=0. Advance set; on set wrap (TLB_ENTRIES-1 → 0) advance way.
  - If the last way has wrapped, go to DONE.
  - Otherwise compute the next entry and go to WRITE.
  - Minimum 2 cycles per entry; total ≥ 2·TLB_ENTRIES·TLB_WAYS + 1.
- DONE: busy=0; done=1; wr_req=0. start → ARM.
- start in ARM/WRITE/NEXT is ignored (no restart mid-walk). start in IDLE or DONE begins a walk.
- Entry computation (combinational, registered into entry at ARM/NEXT):
  - Region r hits iff REG_COUNT[r]≠0, way==ATTR[r].way, and REG_START[r] ≤ set < REG_START[r]+REG_COUNT[r] (17-bit compare, no wrap).
  - Lowest-numbered hit region wins on overlap.
  - On hit, with k = set − REG_START[r]:
    - pte.v=1
    - pte.ppn = (REG_PA[r]>>LOG_PAGESIZE)+k, truncated to ppn width
    - vpn = ((REG_VA[r]>>LOG_PAGESIZE)+k) >> WID, truncated to vpn width
    - pte.rwx, pte.lvl and lock taken from ATTR
  - No hit: entry = all-zero (v=0, lock=0).
  - ppn/vpn derive from k. There is no chaining through a previous entry.
- Reset asserted mid-walk: immediate abort to reset values. After release, AUTO_START restarts from (0,0).
- Regions running past TLB_ENTRIES-1 are clipped. There is no wrap into set 0.

Decomposition:
- mmu_pkg: tlb_entry_t (existing); new tlb_region_attr_t {lock, lvl, rwx, way}; typedef tlb_init_state_e.
- Sub-module tlb_region_match: combinational. Takes set, way and the region tables; returns hit, region index and k. Priority encoder plus adders.
- Top module holds the FSM, counters and output registers.

Test Plan:
- Defaults, TLB_ENTRIES=8, TLB_WAYS=2, region0 START=4, COUNT=3, VA=PA=0xFF800000, ATTR way0 rwx7, wr_ack tied 1 → 16 writes. Way0 sets 4,5,6 have v=1 with ppn 0x7FC00,0x7FC01,0x7FC02. All other writes have v=0. done rises at cycle 33 after release.
- wr_ack held 0 for 5 cycles on the 3rd write → entry/entry_no/wr_way stable throughout; no skipped or duplicated index.
- Region0 and region1 overlap on set 5 with different PA → set 5 carries region0 ppn.
- Region START=6, COUNT=4, TLB_ENTRIES=8 → only sets 6,7 are valid; set 0 has v=0.
- start pulsed mid-walk → ignored. start pulsed in DONE → done drops next cycle and the full walk repeats with identical data.
- rst_n asserted during write 5 → wr_req/busy go 0 asynchronously. After release the walk restarts at way0/set0.
